data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Parametrised successor to the core's word-only data RAM.
- Word-organised synchronous memory behind a load/store front end with a valid/ready request handshake.
- Supports byte, halfword and word accesses: byte-lane write enables, sign/zero extension on loads, misalignment and range error reporting, and configurable read wait states.
- Sits between the core's MEM stage and the data array; the core stalls while req_ready is low.

Parameters:
DATA_W, 32, word width in bits; fixed at 32 for lane decoding.
DEPTH, 256, number of words; power of two, 16..65536.
ADDR_W, 32, byte-address width of req_addr.
RD_WAIT, 1, extra wait cycles on loads; range 0..7.

Ports:
clka  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
req_addr  in  ADDR_W  byte address, little-endian.
req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  out  1  single-cycle response pulse.
rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
rsp_err  out  1  request rejected (misaligned, illegal size, out of range).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, wait counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0.
  - Array contents are not reset.
- Acceptance and readiness:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_ready = 1 only in IDLE with rst_n high.
  - Only one request is outstanding at a time.
- State machine:
  - IDLE: on accept with error → RESP. On store → RESP. On load with RD_WAIT = 0 → RESP. On load with RD_WAIT > 0 → WAIT, counter = RD_WAIT.
  - WAIT: counter decrements each cycle; when counter = 1 → RESP.
  - RESP: rsp_valid = 1 for exactly one cycle → IDLE.
- Latency, counted from the accept edge to the cycle in which rsp_valid is high:
  - Stores and errors: 1 cycle.
  - Loads: 1 + RD_WAIT cycles.
  - There is no response backpressure.
- Error detection at accept; any condition sets rsp_err = 1:
  - req_size = 11.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 00.
  - req_addr >= DEPTH*4.
  - An errored store writes nothing. An errored request returns rsp_rdata = 0.
- Addressing: word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0].
- Stores: the write happens on the accept edge using byte enables.
  - Byte: lane = addr[1:0]; wdata[7:0] is written to that lane.
  - Halfword: lanes {addr[1],0} and {addr[1],1}; wdata[15:0] is written.
  - Word: all four lanes are written.
  - Unselected lanes are unchanged.
- Loads:
  - The word is captured on the accept edge.
  - The selected lane(s) are shifted to bit 0, then extended per req_unsigned. Word loads ignore req_unsigned.
  - The result is held in a register and driven on rsp_rdata only while rsp_valid = 1; otherwise rsp_rdata = 0.
- rsp_err is 0 whenever rsp_valid = 0.
- Reset mid-operation:
  - The pending response is dropped and no rsp_valid is issued.
  - A store accepted before reset remains written.
- req_valid while req_ready = 0 is ignored; the requester must hold the request.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 (RD_WAIT=1) → store rsp_valid 1 cycle after accept, err=0; load rsp_valid 2 cycles after accept, rdata=0xDEADBEEF.
- Byte store 0x7F @0x11, then byte store 0x80 @0x12 over 0x00000000 @0x10 → word load @0x10 = 0x00807F00; byte load @0x12 signed = 0xFFFFFF80, unsigned = 0x00000080.
- Halfword store 0x8001 @0x22, then halfword load @0x22 signed → 0xFFFF8001; word load @0x20 → upper half 0x8001, lower half unchanged.
- Misaligned word load @0x13, halfword store @0x21, size=11, and addr=DEPTH*4 → each gives rsp_err=1, rdata=0, 1-cycle latency; memory unchanged (verify by reload).
- Back-to-back: req_valid held high across 4 loads with RD_WAIT=3 → req_ready low during WAIT/RESP; each response 4 cycles after its accept; next accept the cycle after rsp_valid.
- Assert rst_n low during WAIT of a load → no rsp_valid, outputs 0 immediately; after release req_ready=1 and a previously stored word reads back intact.

Source files
------------

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - load/store unit in front of a word-organised data RAM
//
// Byte/halfword/word loads and stores over a DEPTH x 32-bit array, with a
// valid/ready request handshake and a single-cycle response pulse.
//
// Ports:
//   clka          clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset (array contents are kept)
//   req_valid     request present
//   req_ready     high only in IDLE while out of reset
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  loads zero-extend when 1, sign-extend when 0
//   req_addr      little-endian byte address
//   req_wdata     right-aligned store data
//   rsp_valid     one-cycle response pulse
//   rsp_rdata     load result while rsp_valid, otherwise 0
//   rsp_err       request rejected (misaligned, illegal size, out of range)
module data_mem_lsu #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int RD_WAIT = 1
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [2:0]        wait_cnt;
    logic [DATA_W-1:0] load_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic              out_of_range;
    logic              misaligned;
    logic              req_err;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] wlanes;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_data;

    assign req_ready = (state == S_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[IDX_W+1:2];
    assign lane      = req_addr[1:0];

    // Any address bit above the array span means the access is out of range.
    if (ADDR_W > IDX_W + 2) begin : g_range
        assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_norange
        assign out_of_range = 1'b0;
    end

    assign misaligned = ((req_size == 2'b01) && lane[0]) ||
                        ((req_size == 2'b10) && (lane != 2'b00));
    assign req_err    = (req_size == 2'b11) || misaligned || out_of_range;

    // Store data is replicated across lanes so each byte enable picks its own copy.
    always_comb begin
        byte_en = 4'b0000;
        wlanes  = '0;
        case (req_size)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wlanes  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wlanes  = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wlanes  = req_wdata;
            end
            default: begin
                byte_en = 4'b0000;
                wlanes  = '0;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (accept && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    // Load path: select lane(s), move them to bit 0, then extend.
    always_comb begin
        rd_word   = mem[word_idx];
        shifted   = rd_word >> {lane, 3'b000};
        load_data = '0;
        case (req_size)
            2'b00: load_data = {{(DATA_W-8){shifted[7] & ~req_unsigned}}, shifted[7:0]};
            2'b01: load_data = {{(DATA_W-16){shifted[15] & ~req_unsigned}}, shifted[15:0]};
            2'b10: load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 3'd0;
            load_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else if (RD_WAIT == 0) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= load_data;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_INIT;
                            load_q   <= load_data;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd1) begin
                        state     <= S_RESP;
                        wait_cnt  <= 3'd0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_q;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - byte-level reference model bench for data_mem_lsu
module tb_data_mem_lsu;

    localparam int DEPTH = 256;
    localparam int NB    = DEPTH * 4;
    localparam int RDW0  = 1;
    localparam int RDW1  = 3;

    logic        clka = 1'b0;
    logic        rst_n;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];

    always #5 clka = ~clka;

    data_mem_lsu #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_WAIT(RDW0)) u_dut0 (
        .clka(clka), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_mem_lsu #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_WAIT(RDW1)) u_dut1 (
        .clka(clka), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    typedef struct {
        int          due;
        int          acc;
        logic [31:0] rd;
        bit          er;
        bit          known;
        bit          lit;
        logic [31:0] lrd;
        bit          ler;
        int          llat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] mbyte  [2][NB];
    bit         mknown [2][NB];

    bit          lit_en  [2];
    logic [31:0] lit_rd  [2];
    bit          lit_er  [2];
    int          lit_lat [2];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge clka) cyc++;

    function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc%0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endfunction

    // Reference: memory as a flat little-endian byte array.
    function automatic void model(int k, bit we, logic [1:0] size, bit uns,
                                  logic [31:0] addr, logic [31:0] wd, output exp_t e);
        int          n;
        logic [31:0] v;
        e = '{default: 0};
        e.er = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
               (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'(NB));
        e.rd = 32'd0;
        e.known = 1'b1;
        if (!e.er) begin
            n = 1 << size;
            if (we) begin
                for (int i = 0; i < n; i++) begin
                    mbyte[k][int'(addr) + i]  = wd[8*i +: 8];
                    mknown[k][int'(addr) + i] = 1'b1;
                end
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) begin
                    v = v | (32'(mbyte[k][int'(addr) + i]) << (8 * i));
                    e.known = e.known & mknown[k][int'(addr) + i];
                end
                if (!uns && size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (!uns && size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
                e.rd = v;
            end
        end
        e.due = cyc + ((we || e.er) ? 1 : 1 + ((k == 0) ? RDW0 : RDW1));
        e.acc = cyc + 1;
    endfunction

    always @(negedge clka) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            bit   busy;
            bit   hit;
            e = '{default: 0};
            busy = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (busy) e = (k == 0) ? q0[0] : q1[0];
            if (!rst_n) begin
                if (k == 0) q0.delete(); else q1.delete();
                chk("reset_valid", k, 32'(rsp_valid[k]), 32'd0);
                chk("reset_rdata", k, rsp_rdata[k], 32'd0);
                chk("reset_err", k, 32'(rsp_err[k]), 32'd0);
                chk("reset_ready", k, 32'(req_ready[k]), 32'd0);
            end else begin
                hit = busy && (e.due == cyc);
                if (hit) begin
                    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
                chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(hit));
                chk("rsp_err", k, 32'(rsp_err[k]), hit ? 32'(e.er) : 32'd0);
                if (!hit || e.known)
                    chk("rsp_rdata", k, rsp_rdata[k], hit ? e.rd : 32'd0);
                if (hit && e.lit) begin
                    chk("lit_rdata", k, rsp_rdata[k], e.lrd);
                    chk("lit_err", k, 32'(rsp_err[k]), 32'(e.ler));
                    chk("lit_latency", k, 32'(cyc - e.acc + 1), 32'(e.llat));
                end
                chk("req_ready", k, 32'(req_ready[k]), 32'(!busy));
                if (!busy && req_valid[k]) begin
                    model(k, req_we[k], req_size[k], req_unsigned[k], req_addr[k], req_wdata[k], e);
                    e.lit  = lit_en[k];
                    e.lrd  = lit_rd[k];
                    e.ler  = lit_er[k];
                    e.llat = lit_lat[k];
                    if (k == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
        end
    end

    task automatic timeout_fail(string what);
        $display("FAIL timeout waiting for %s at cyc%0d", what, cyc);
        $fatal(1, "bench stopped");
    endtask

    task automatic wait_ready(int k);
        int n = 0;
        while (!req_ready[k]) begin
            @(posedge clka); #1;
            n++;
            if (n > 50) timeout_fail("req_ready");
        end
    endtask

    task automatic wait_rsp(int k);
        int n = 0;
        while (!rsp_valid[k]) begin
            @(posedge clka); #1;
            n++;
            if (n > 20) timeout_fail("rsp_valid");
        end
    endtask

    task automatic issue(int k, bit we, logic [1:0] size, bit uns, logic [31:0] addr, logic [31:0] wd);
        req_we[k] = we; req_size[k] = size; req_unsigned[k] = uns;
        req_addr[k] = addr; req_wdata[k] = wd; req_valid[k] = 1'b1;
        wait_ready(k);
        @(posedge clka); #1;
        req_valid[k] = 1'b0;
        lit_en[k] = 1'b0;
        wait_rsp(k);
    endtask

    task automatic issue_lit(int k, bit we, logic [1:0] size, bit uns, logic [31:0] addr,
                             logic [31:0] wd, logic [31:0] erd, bit eer, int elat);
        lit_en[k] = 1'b1; lit_rd[k] = erd; lit_er[k] = eer; lit_lat[k] = elat;
        issue(k, we, size, uns, addr, wd);
    endtask

    logic [31:0] bvals [4];

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cyc%0d", cyc);
        $fatal(1, "bench stopped");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_we[k] = 0; req_size[k] = 0; req_unsigned[k] = 0;
            req_addr[k] = 0; req_wdata[k] = 0;
            lit_en[k] = 0; lit_rd[k] = 0; lit_er[k] = 0; lit_lat[k] = 0;
        end
        repeat (3) @(posedge clka);
        #1 rst_n = 1'b1;

        // Word store then word load, RD_WAIT=1
        issue_lit(0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1);
        issue_lit(0, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 2);

        // Byte stores over a zeroed word, then word and byte loads
        issue_lit(0, 1, 2'd2, 0, 32'h10, 32'h0, 32'h0, 0, 1);
        issue_lit(0, 1, 2'd0, 0, 32'h11, 32'h7F, 32'h0, 0, 1);
        issue_lit(0, 1, 2'd0, 0, 32'h12, 32'h80, 32'h0, 0, 1);
        issue_lit(0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h0080_7F00, 0, 2);
        issue_lit(0, 0, 2'd0, 0, 32'h12, 32'h0, 32'hFFFF_FF80, 0, 2);
        issue_lit(0, 0, 2'd0, 1, 32'h12, 32'h0, 32'h0000_0080, 0, 2);

        // Halfword store into upper half
        issue_lit(0, 1, 2'd2, 0, 32'h20, 32'h1234_5678, 32'h0, 0, 1);
        issue_lit(0, 1, 2'd1, 0, 32'h22, 32'h0000_8001, 32'h0, 0, 1);
        issue_lit(0, 0, 2'd1, 0, 32'h22, 32'h0, 32'hFFFF_8001, 0, 2);
        issue_lit(0, 0, 2'd2, 0, 32'h20, 32'h0, 32'h8001_5678, 0, 2);

        // Errors: no write, rdata 0, one-cycle latency
        issue_lit(0, 1, 2'd2, 0, 32'h0, 32'h0BAD_F00D, 32'h0, 0, 1);
        issue_lit(0, 0, 2'd2, 0, 32'h13, 32'h0, 32'h0, 1, 1);
        issue_lit(0, 1, 2'd1, 0, 32'h21, 32'hFFFF_FFFF, 32'h0, 1, 1);
        issue_lit(0, 1, 2'd3, 0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1, 1);
        issue_lit(0, 0, 2'd2, 0, 32'(NB), 32'h0, 32'h0, 1, 1);
        issue_lit(0, 1, 2'd2, 0, 32'(NB), 32'hAAAA_AAAA, 32'h0, 1, 1);
        issue_lit(0, 0, 2'd2, 0, 32'h20, 32'h0, 32'h8001_5678, 0, 2);
        issue_lit(0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h0080_7F00, 0, 2);
        issue_lit(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h0BAD_F00D, 0, 2);

        // Back-to-back loads with req_valid held, RD_WAIT=3
        bvals[0] = 32'h1111_1111; bvals[1] = 32'h2222_2222;
        bvals[2] = 32'h8765_4321; bvals[3] = 32'hFEDC_BA98;
        for (int i = 0; i < 4; i++)
            issue_lit(1, 1, 2'd2, 0, 32'h100 + 32'(4 * i), bvals[i], 32'h0, 0, 1);
        req_we[1] = 0; req_size[1] = 2'd2; req_unsigned[1] = 0; req_addr[1] = 32'h100;
        lit_en[1] = 1; lit_rd[1] = bvals[0]; lit_er[1] = 0; lit_lat[1] = 4;
        req_valid[1] = 1;
        for (int i = 0; i < 4; i++) begin
            wait_ready(1);
            @(posedge clka); #1;
            if (i < 3) begin
                req_addr[1] = 32'h100 + 32'(4 * (i + 1));
                lit_rd[1] = bvals[i + 1];
            end else begin
                req_valid[1] = 0;
                lit_en[1] = 0;
            end
            wait_rsp(1);
        end

        // Reset during WAIT of a load
        issue_lit(0, 1, 2'd2, 0, 32'h40, 32'hCAFE_F00D, 32'h0, 0, 1);
        req_we[0] = 0; req_size[0] = 2'd2; req_addr[0] = 32'h40; req_valid[0] = 1;
        wait_ready(0);
        @(posedge clka); #1;
        req_valid[0] = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clka);
        #1 rst_n = 1'b1;
        issue_lit(0, 0, 2'd2, 0, 32'h40, 32'h0, 32'hCAFE_F00D, 0, 2);

        // Randomized traffic on both instances
        for (int i = 0; i < 300; i++) begin
            int          k;
            int          r;
            logic [1:0]  sz;
            logic [31:0] a;
            k = i % 2;
            r = int'($urandom_range(0, 7));
            sz = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            r = int'($urandom_range(0, 15));
            if (r == 0)      a = 32'(NB) + 32'($urandom_range(0, 63));
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else             a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (3) @(posedge clka);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
